// File: rtl/usb_packet_decoder.sv
// USB protocol-layer packet decoder: PID check, token/data/handshake split, CRC5/CRC16 check, payload forwarding.
// Optional macro USB_PKT_CRC16_CHECK_EN enables the DATA-packet CRC16 check (err_code 3).
module usb_packet_decoder #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_eop,
  output logic [3:0] pid,
  output logic       token_valid,
  output logic [6:0] addr,
  output logic [3:0] endp,
  output logic       hs_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [2:0] err_code
);
  localparam int CW = $clog2(MAX_PAYLOAD + 4);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] OVF  = CW'(MAX_PAYLOAD + 2);

  typedef enum logic [2:0] {S_IDLE, S_TOKEN, S_DATA, S_HS, S_ERR} state_e;

  state_e          st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_n;
  logic [4:0]      crc5_q, crc5_d;
  logic [7:0]      dly0_q, dly0_d, dly1_q, dly1_d;
  logic [3:0]      pid_q, pid_d;
  logic [6:0]      addr_q, addr_d;
  logic [3:0]      endp_q, endp_d;
  logic [7:0]      od_q, od_d;
  logic [2:0]      err_q, err_d;
  logic            tok_q, tok_d, hs_q, hs_d, ov_q, ov_d, done_q, done_d, perr_q, perr_d;
`ifdef USB_PKT_CRC16_CHECK_EN
  logic [15:0]     crc16_q, crc16_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h8005) : {r[14:0], 1'b0};
    return r;
  endfunction
`endif

  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[4] ^ d[i]) ? ({r[3:0], 1'b0} ^ 5'b00101) : {r[3:0], 1'b0};
    return r;
  endfunction

  assign cnt_n = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    st_d = st_q;   cnt_d = cnt_q;   crc5_d = crc5_q;
    dly0_d = dly0_q; dly1_d = dly1_q;
    pid_d = pid_q; addr_d = addr_q; endp_d = endp_q; od_d = od_q; err_d = err_q;
    tok_d = 1'b0; hs_d = 1'b0; ov_d = 1'b0; done_d = 1'b0; perr_d = 1'b0;
`ifdef USB_PKT_CRC16_CHECK_EN
    crc16_d = crc16_q;
`endif
    // Byte stage first, so a same-cycle eop sees the updated state.
    if (rx_valid) begin
      case (st_q)
        S_IDLE: begin
          pid_d  = rx_data[3:0];
          err_d  = 3'd0;
          cnt_d  = '0;
          crc5_d = 5'h1F;
`ifdef USB_PKT_CRC16_CHECK_EN
          crc16_d = 16'hFFFF;
`endif
          if (rx_data[7:4] != ~rx_data[3:0]) begin
            st_d = S_ERR; err_d = 3'd1;
          end else if (rx_data[1:0] == 2'b01 || rx_data[3:0] == 4'b0100) st_d = S_TOKEN;
          else if (rx_data[1:0] == 2'b11) st_d = S_DATA;
          else if (rx_data[1:0] == 2'b10) st_d = S_HS;
          else begin
            st_d = S_ERR; err_d = 3'd6;
          end
        end
        S_TOKEN: begin
          cnt_d  = cnt_n;
          crc5_d = crc5_byte(crc5_q, rx_data);
          if (cnt_q == '0) dly0_d = rx_data;
          if (cnt_q == CW'(1)) dly1_d = rx_data;
        end
        S_HS: cnt_d = cnt_n;
        S_DATA: begin
          cnt_d = cnt_n;
          if (cnt_n > OVF) begin
            st_d = S_ERR; err_d = 3'd5;
          end else begin
`ifdef USB_PKT_CRC16_CHECK_EN
            crc16_d = crc16_byte(crc16_q, rx_data);
`endif
            // Two-byte delay line holds back what may turn out to be the CRC.
            if (cnt_q >= CW'(2)) begin
              ov_d = 1'b1; od_d = dly0_q;
            end
            dly0_d = dly1_q;
            dly1_d = rx_data;
          end
        end
        default: ;
      endcase
    end
    if (rx_eop) begin
      done_d = 1'b1;
      case (st_d)
        S_IDLE: begin perr_d = 1'b1; err_d = 3'd4; end
        S_TOKEN: begin
          if (cnt_d != CW'(2)) begin perr_d = 1'b1; err_d = 3'd4; end
          else if (crc5_d != 5'b01100) begin perr_d = 1'b1; err_d = 3'd2; end
          else begin
            tok_d = 1'b1; addr_d = dly0_d[6:0]; endp_d = {dly1_d[2:0], dly0_d[7]};
          end
        end
        S_HS: begin
          if (cnt_d != '0) begin perr_d = 1'b1; err_d = 3'd4; end
          else hs_d = 1'b1;
        end
        S_DATA: begin
          if (cnt_d < CW'(2)) begin perr_d = 1'b1; err_d = 3'd4; end
`ifdef USB_PKT_CRC16_CHECK_EN
          else if (crc16_d != 16'h800D) begin perr_d = 1'b1; err_d = 3'd3; end
`endif
        end
        default: perr_d = 1'b1;
      endcase
      st_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      st_q <= S_IDLE; cnt_q <= '0; crc5_q <= 5'h1F; dly0_q <= '0; dly1_q <= '0;
      pid_q <= '0; addr_q <= '0; endp_q <= '0; od_q <= '0; err_q <= '0;
      tok_q <= 1'b0; hs_q <= 1'b0; ov_q <= 1'b0; done_q <= 1'b0; perr_q <= 1'b0;
`ifdef USB_PKT_CRC16_CHECK_EN
      crc16_q <= 16'hFFFF;
`endif
    end else begin
      st_q <= st_d; cnt_q <= cnt_d; crc5_q <= crc5_d; dly0_q <= dly0_d; dly1_q <= dly1_d;
      pid_q <= pid_d; addr_q <= addr_d; endp_q <= endp_d; od_q <= od_d; err_q <= err_d;
      tok_q <= tok_d; hs_q <= hs_d; ov_q <= ov_d; done_q <= done_d; perr_q <= perr_d;
`ifdef USB_PKT_CRC16_CHECK_EN
      crc16_q <= crc16_d;
`endif
    end
  end

  assign pid         = pid_q;
  assign token_valid = tok_q;
  assign addr        = addr_q;
  assign endp        = endp_q;
  assign hs_valid    = hs_q;
  assign out_data    = od_q;
  assign out_valid   = ov_q;
  assign pkt_done    = done_q;
  assign pkt_err     = perr_q;
  assign err_code    = err_q;
endmodule

// File: tb/tb_usb_packet_decoder.sv
// Directed bench for usb_packet_decoder: known-good USB packets, corrupted variants, length/overflow and reset cases.
module tb_usb_packet_decoder;
  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, rx_eop = 1'b0;
  logic [3:0] pid, endp;
  logic [6:0] addr;
  logic       token_valid, hs_valid, out_valid, pkt_done, pkt_err;
  logic [7:0] out_data;
  logic [2:0] err_code;

  usb_packet_decoder #(.MAX_PAYLOAD(64)) dut (
    .clk(clk), .nRST(nRST), .rx_data(rx_data), .rx_valid(rx_valid), .rx_eop(rx_eop),
    .pid(pid), .token_valid(token_valid), .addr(addr), .endp(endp), .hs_valid(hs_valid),
    .out_data(out_data), .out_valid(out_valid), .pkt_done(pkt_done), .pkt_err(pkt_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cmp = 0, mis = 0;
  logic [7:0] pkt[$];
  logic [7:0] outq[$];
  int n_tok = 0, n_hs = 0, n_done = 0;
  logic last_perr = 1'b0;
  logic [2:0] last_err = '0;

  // Outputs change on posedge only; sample them on negedge.
  always @(negedge clk) begin
    if (out_valid) outq.push_back(out_data);
    if (token_valid) n_tok++;
    if (hs_valid) n_hs++;
    if (pkt_done) begin
      n_done++; last_perr = pkt_err; last_err = err_code;
    end
  end

  int s_tok, s_hs, s_done, s_out;

  task automatic run_pkt(input bit same_eop);
    s_tok = n_tok; s_hs = n_hs; s_done = n_done; s_out = outq.size();
    foreach (pkt[i]) begin
      @(negedge clk);
      rx_data = pkt[i]; rx_valid = 1'b1; rx_eop = same_eop && (i == pkt.size() - 1);
    end
    if (!same_eop) begin
      @(negedge clk); rx_valid = 1'b0; rx_eop = 1'b1;
    end
    @(negedge clk); rx_valid = 1'b0; rx_eop = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    cmp++;
    if ({pid, addr, endp, out_data, err_code} !== 26'd0 ||
        {token_valid, hs_valid, out_valid, pkt_done, pkt_err} !== 5'd0) begin
      mis++; $display("FAIL reset_state: pid=%h addr=%h endp=%h od=%h err=%0d strobes=%b want all 0",
                      pid, addr, endp, out_data, err_code,
                      {token_valid, hs_valid, out_valid, pkt_done, pkt_err});
    end
  endtask

  task automatic test_token();
    pkt = '{8'h2D, 8'h00, 8'h10}; run_pkt(1'b0);
    cmp++;
    if (n_tok - s_tok !== 1 || n_done - s_done !== 1 || last_perr !== 1'b0 ||
        pid !== 4'hD || addr !== 7'd0 || endp !== 4'd0) begin
      mis++; $display("FAIL setup_token: tok=%0d done=%0d perr=%b pid=%h addr=%h endp=%h want 1 1 0 D 0 0",
                      n_tok - s_tok, n_done - s_done, last_perr, pid, addr, endp);
    end
    pkt = '{8'hB4, 8'h00, 8'h10}; run_pkt(1'b1);
    cmp++;
    if (n_tok - s_tok !== 1 || last_perr !== 1'b0 || pid !== 4'h4 || n_done - s_done !== 1) begin
      mis++; $display("FAIL ping_same_eop: tok=%0d perr=%b pid=%h done=%0d want 1 0 4 1",
                      n_tok - s_tok, last_perr, pid, n_done - s_done);
    end
    pkt = '{8'h2D, 8'h00, 8'h11}; run_pkt(1'b0);
    cmp++;
    if (n_tok - s_tok !== 0 || n_done - s_done !== 1 || last_perr !== 1'b1 || last_err !== 3'd2) begin
      mis++; $display("FAIL bad_crc5: tok=%0d done=%0d perr=%b err=%0d want 0 1 1 2",
                      n_tok - s_tok, n_done - s_done, last_perr, last_err);
    end
    pkt = '{8'h2D, 8'h00}; run_pkt(1'b0);
    cmp++;
    if (n_tok - s_tok !== 0 || last_perr !== 1'b1 || last_err !== 3'd4) begin
      mis++; $display("FAIL token_short: tok=%0d perr=%b err=%0d want 0 1 4", n_tok - s_tok, last_perr, last_err);
    end
  endtask

  task automatic test_data();
    logic [7:0] exp[8];
    exp = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    run_pkt(1'b0);
    cmp++;
    if (outq.size() - s_out !== 8 || last_perr !== 1'b0 || n_done - s_done !== 1 || pid !== 4'h3) begin
      mis++; $display("FAIL data0_good: nout=%0d perr=%b done=%0d pid=%h want 8 0 1 3",
                      outq.size() - s_out, last_perr, n_done - s_done, pid);
    end
    for (int i = 0; i < 8; i++) begin
      cmp++;
      if (s_out + i >= outq.size() || outq[s_out + i] !== exp[i]) begin
        mis++; $display("FAIL data0_byte%0d: got %h want %h", i,
                        (s_out + i < outq.size()) ? outq[s_out + i] : 8'hXX, exp[i]);
      end
    end
    pkt[10] = 8'h95; run_pkt(1'b0);
    cmp++;
`ifdef USB_PKT_CRC16_CHECK_EN
    if (outq.size() - s_out !== 8 || last_perr !== 1'b1 || last_err !== 3'd3) begin
      mis++; $display("FAIL data0_badcrc: nout=%0d perr=%b err=%0d want 8 1 3", outq.size() - s_out, last_perr, last_err);
    end
`else
    if (outq.size() - s_out !== 8 || last_perr !== 1'b0 || last_err !== 3'd0) begin
      mis++; $display("FAIL data0_badcrc: nout=%0d perr=%b err=%0d want 8 0 0", outq.size() - s_out, last_perr, last_err);
    end
`endif
    pkt = '{8'h4B, 8'h00, 8'h00}; run_pkt(1'b0);
    cmp++;
    if (outq.size() - s_out !== 0 || n_done - s_done !== 1 || last_perr !== 1'b0 || pid !== 4'hB) begin
      mis++; $display("FAIL data1_zlp: nout=%0d done=%0d perr=%b pid=%h want 0 1 0 B",
                      outq.size() - s_out, n_done - s_done, last_perr, pid);
    end
    pkt = '{8'hC3, 8'h80}; run_pkt(1'b0);
    cmp++;
    if (outq.size() - s_out !== 0 || last_perr !== 1'b1 || last_err !== 3'd4) begin
      mis++; $display("FAIL data_short: nout=%0d perr=%b err=%0d want 0 1 4", outq.size() - s_out, last_perr, last_err);
    end
  endtask

  task automatic test_handshake();
    pkt = '{8'hD2}; run_pkt(1'b0);
    cmp++;
    if (n_hs - s_hs !== 1 || pid !== 4'h2 || last_perr !== 1'b0 || last_err !== 3'd0 || n_done - s_done !== 1) begin
      mis++; $display("FAIL ack: hs=%0d pid=%h perr=%b err=%0d done=%0d want 1 2 0 0 1",
                      n_hs - s_hs, pid, last_perr, last_err, n_done - s_done);
    end
    pkt = '{8'h5A}; run_pkt(1'b1);
    cmp++;
    if (n_hs - s_hs !== 1 || pid !== 4'hA || last_perr !== 1'b0) begin
      mis++; $display("FAIL nak_same_eop: hs=%0d pid=%h perr=%b want 1 A 0", n_hs - s_hs, pid, last_perr);
    end
    pkt = '{8'hD2, 8'h00}; run_pkt(1'b0);
    cmp++;
    if (n_hs - s_hs !== 0 || last_perr !== 1'b1 || last_err !== 3'd4) begin
      mis++; $display("FAIL hs_long: hs=%0d perr=%b err=%0d want 0 1 4", n_hs - s_hs, last_perr, last_err);
    end
  endtask

  task automatic test_errors();
    pkt = '{8'h2C, 8'h00, 8'h10}; run_pkt(1'b0);
    cmp++;
    if (n_tok - s_tok !== 0 || n_done - s_done !== 1 || last_perr !== 1'b1 || last_err !== 3'd1) begin
      mis++; $display("FAIL bad_pid: tok=%0d done=%0d perr=%b err=%0d want 0 1 1 1",
                      n_tok - s_tok, n_done - s_done, last_perr, last_err);
    end
    pkt = '{8'h78}; run_pkt(1'b0);
    cmp++;
    if (last_perr !== 1'b1 || last_err !== 3'd6 || n_hs - s_hs !== 0) begin
      mis++; $display("FAIL unsupported_pid: perr=%b err=%0d hs=%0d want 1 6 0", last_perr, last_err, n_hs - s_hs);
    end
    // err_code must hold after pkt_done until the next PID byte
    repeat (3) @(negedge clk);
    cmp++;
    if (err_code !== 3'd6) begin
      mis++; $display("FAIL err_hold: err=%0d want 6", err_code);
    end
    pkt.delete(); run_pkt(1'b0);
    cmp++;
    if (n_done - s_done !== 1 || last_perr !== 1'b1 || last_err !== 3'd4) begin
      mis++; $display("FAIL idle_eop: done=%0d perr=%b err=%0d want 1 1 4", n_done - s_done, last_perr, last_err);
    end
    // 65 payload bytes + 2 more: overflow on the 67th post-PID byte
    pkt = '{8'hC3};
    for (int i = 0; i < 67; i++) pkt.push_back(8'(i + 1));
    pkt.push_back(8'hAA);
    run_pkt(1'b0);
    cmp++;
    if (outq.size() - s_out !== 64 || n_done - s_done !== 1 || last_perr !== 1'b1 || last_err !== 3'd5) begin
      mis++; $display("FAIL overflow: nout=%0d done=%0d perr=%b err=%0d want 64 1 1 5",
                      outq.size() - s_out, n_done - s_done, last_perr, last_err);
    end
    cmp++;
    if (outq.size() < 64 || outq[outq.size() - 1] !== 8'd64) begin
      mis++; $display("FAIL overflow_last: got %h want 40", (outq.size() > 0) ? outq[outq.size() - 1] : 8'hXX);
    end
    // exactly 64 payload bytes is still legal (CRC not valid, so only length/overflow is judged)
    pkt = '{8'hC3};
    for (int i = 0; i < 66; i++) pkt.push_back(8'(i));
    run_pkt(1'b0);
    cmp++;
    if (outq.size() - s_out !== 64 || last_err === 3'd5 || last_err === 3'd4) begin
      mis++; $display("FAIL max_payload: nout=%0d err=%0d want 64 and no 4/5", outq.size() - s_out, last_err);
    end
  endtask

  task automatic test_reset_mid();
    s_done = n_done; s_out = outq.size(); s_tok = n_tok; s_hs = n_hs;
    pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01};
    foreach (pkt[i]) begin
      @(negedge clk); rx_data = pkt[i]; rx_valid = 1'b1;
    end
    @(negedge clk); rx_valid = 1'b0; nRST = 1'b0;
    @(negedge clk);
    s_out = outq.size();
    cmp++;
    if ({pid, addr, endp, out_data, err_code} !== 26'd0 ||
        {token_valid, hs_valid, out_valid, pkt_done, pkt_err} !== 5'd0) begin
      mis++; $display("FAIL reset_mid: pid=%h od=%h err=%0d strobes=%b want all 0", pid, out_data, err_code,
                      {token_valid, hs_valid, out_valid, pkt_done, pkt_err});
    end
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    repeat (2) @(negedge clk);
    cmp++;
    if (n_done - s_done !== 0 || outq.size() - s_out !== 0) begin
      mis++; $display("FAIL reset_abort: done=%0d nout=%0d want 0 0", n_done - s_done, outq.size() - s_out);
    end
    // trailing eop now lands in IDLE
    pkt.delete(); run_pkt(1'b0);
    cmp++;
    if (n_done - s_done !== 1 || last_err !== 3'd4 || last_perr !== 1'b1) begin
      mis++; $display("FAIL reset_idle: done=%0d err=%0d perr=%b want 1 4 1", n_done - s_done, last_err, last_perr);
    end
  endtask

  task automatic test_back_to_back();
    pkt = '{8'h2D, 8'h00, 8'h10}; run_pkt(1'b0);
    pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    run_pkt(1'b1);
    cmp++;
    if (outq.size() - s_out !== 8 || last_perr !== 1'b0 || n_done - s_done !== 1) begin
      mis++; $display("FAIL b2b_data_same_eop: nout=%0d perr=%b done=%0d want 8 0 1",
                      outq.size() - s_out, last_perr, n_done - s_done);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    nRST = 1'b1;
    @(negedge clk);
    test_token();
    test_data();
    test_handshake();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
